// File: rtl/pmp_arb_pkg.sv
// Shared types for the arbitrated PMP/DMP checker: request operands, CSR
// layouts and the reconfiguration FSM states.
package pmp_arb_pkg;

  localparam int unsigned CHK_PLEN = 34;

  typedef enum logic [2:0] {
    ACCESS_NONE  = 3'b000,
    ACCESS_READ  = 3'b001,
    ACCESS_WRITE = 3'b010,
    ACCESS_EXEC  = 3'b100
  } pmp_access_t;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } priv_lvl_t;

  // DOMI is the wildcard domain: it matches any entry domain.
  typedef enum logic [1:0] {DOMI = 2'd0, D1 = 2'd1, D2 = 2'd2, D3 = 2'd3} dmp_domain_t;

  typedef enum logic [1:0] {PMP_OFF, PMP_TOR, PMP_NA4, PMP_NAPOT} pmp_addr_mode_t;

  typedef struct packed {
    logic           locked;
    logic [1:0]     reserved;
    pmp_addr_mode_t addr_mode;
    logic [2:0]     access_type;  // {x, w, r}
  } pmpcfg_t;

  typedef struct packed {
    logic [5:0]  reserved;
    dmp_domain_t dom;
  } dmpcfg_t;

  typedef enum logic [1:0] {RUN, DRAIN, HOLD} pmp_arb_state_e;

  typedef struct packed {
    logic [CHK_PLEN-1:0] addr;
    pmp_access_t         access_type;
    priv_lvl_t           priv_lvl;
    dmp_domain_t         expected_dom;
  } pmp_chk_req_t;

  function automatic logic dom_ok(dmp_domain_t entry_dom, dmp_domain_t exp_dom);
    return (exp_dom == DOMI) || (entry_dom == DOMI) || (entry_dom == exp_dom);
  endfunction

endpackage

// File: rtl/pmp_check_arbiter_pmp.sv
// Combinational PMP/DMP checker: lowest-numbered matching entry decides;
// no match allows only M-mode.
module pmp import pmp_arb_pkg::*; #(
  parameter int unsigned PLEN       = 34,
  parameter int unsigned PMP_LEN    = 32,
  parameter int unsigned NR_ENTRIES = 4
) (
  input  logic [PLEN-1:0]          addr_i,
  input  pmp_access_t              access_type_i,
  input  priv_lvl_t                priv_lvl_i,
  input  dmp_domain_t              expected_dom_i,
  input  logic [15:0][PMP_LEN-1:0] conf_addr_i,
  input  pmpcfg_t [15:0]           conf_i,
  input  dmpcfg_t [15:0]           dmpconf_i,
  output logic                     allow_o
);

  logic [PMP_LEN-1:0]    word;
  logic [NR_ENTRIES-1:0] hit;
  logic                  unused_cfg;

  assign word       = PMP_LEN'(addr_i >> 2);
  assign unused_cfg = ^{conf_addr_i, conf_i, dmpconf_i, addr_i};

  for (genvar i = 0; i < NR_ENTRIES; i++) begin : g_entry
    logic [PMP_LEN-1:0] lo;
    logic [PMP_LEN-1:0] mask;

    if (i == 0) begin : g_first
      assign lo = '0;
    end else begin : g_rest
      assign lo = conf_addr_i[i-1];
    end

    // NAPOT: trailing ones in pmpaddr size the region; those bits plus one are don't-care.
    always_comb begin
      logic ones;
      ones = 1'b1;
      mask = '1;
      for (int b = 0; b < int'(PMP_LEN); b++) begin
        mask[b] = !(ones && conf_i[i].addr_mode == PMP_NAPOT);
        ones    = ones & conf_addr_i[i][b];
      end
    end

    assign hit[i] = (conf_i[i].addr_mode == PMP_TOR) ? ((word >= lo) && (word < conf_addr_i[i])) :
                    (conf_i[i].addr_mode == PMP_OFF) ? 1'b0 :
                    (((word ^ conf_addr_i[i]) & mask) == '0);
  end

  // Walk high to low so the lowest matching entry wins.
  always_comb begin
    allow_o = (priv_lvl_i == PRIV_LVL_M);
    for (int i = int'(NR_ENTRIES) - 1; i >= 0; i--) begin
      if (hit[i]) begin
        if (priv_lvl_i == PRIV_LVL_M && !conf_i[i].locked) allow_o = 1'b1;
        else allow_o = ((3'(access_type_i) & conf_i[i].access_type) == 3'(access_type_i)) &&
                       dom_ok(dmpconf_i[i].dom, expected_dom_i);
      end
    end
  end

endmodule

// File: rtl/pmp_check_arbiter.sv
// Round-robin sharing of one PMP checker across requesters, two-stage
// pipeline, and a drain/hold handshake for PMP/DMP reconfiguration.
module pmp_check_arbiter import pmp_arb_pkg::*; #(
  parameter int unsigned PLEN       = CHK_PLEN,
  parameter int unsigned PMP_LEN    = 32,
  parameter int unsigned NR_ENTRIES = 4,
  parameter int          NR_REQ     = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic [NR_REQ-1:0]              req_i,
  input  logic [NR_REQ-1:0][PLEN-1:0]    addr_i,
  input  pmp_access_t [NR_REQ-1:0]       access_type_i,
  input  priv_lvl_t [NR_REQ-1:0]         priv_lvl_i,
  input  dmp_domain_t [NR_REQ-1:0]       expected_dom_i,
  output logic [NR_REQ-1:0]              gnt_o,
  output logic [NR_REQ-1:0]              rsp_valid_o,
  output logic                           rsp_allow_o,
  input  logic [15:0][PMP_LEN-1:0]       conf_addr_i,
  input  pmpcfg_t [15:0]                 pmpconf_i,
  input  dmpcfg_t [15:0]                 dmpconf_i,
  input  logic                           cfg_upd_req_i,
  output logic                           cfg_upd_ack_o
);

  localparam int PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  pmp_arb_state_e    state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [NR_REQ-1:0] s1_id_q, s1_id_d, s2_id_q, s2_id_d;
  pmp_chk_req_t      s1_req_q, s1_req_d;
  logic              s2_allow_q, s2_allow_d;
  logic              grant_en, found, pmp_allow;
  logic [PTR_W-1:0]  sel;

  // Grants are also blocked during reset so nothing is consumed and then lost.
  always_comb begin
    grant_en = (state_q == RUN) && !cfg_upd_req_i && !flush_i && !rst_i;
    gnt_o    = '0;
    sel      = '0;
    found    = 1'b0;
    s1_req_d = s1_req_q;
    for (int i = 0; i < NR_REQ; i++) begin
      if (!found && req_i[i] && i >= int'(rr_ptr_q)) begin
        found = 1'b1;
        sel   = PTR_W'(i);
      end
    end
    for (int i = 0; i < NR_REQ; i++) begin
      if (!found && req_i[i]) begin
        found = 1'b1;
        sel   = PTR_W'(i);
      end
    end
    for (int i = 0; i < NR_REQ; i++) begin
      gnt_o[i] = grant_en && found && (int'(sel) == i);
      if (gnt_o[i]) begin
        s1_req_d.addr         = CHK_PLEN'(addr_i[i]);
        s1_req_d.access_type  = access_type_i[i];
        s1_req_d.priv_lvl     = priv_lvl_i[i];
        s1_req_d.expected_dom = expected_dom_i[i];
      end
    end
  end

  assign rr_ptr_d   = (|gnt_o) ? ((int'(sel) == NR_REQ - 1) ? '0 : sel + 1'b1) : rr_ptr_q;
  assign s1_valid_d = |gnt_o;
  assign s1_id_d    = gnt_o;
  assign s2_valid_d = s1_valid_q && !flush_i;
  assign s2_id_d    = s1_id_q;
  assign s2_allow_d = pmp_allow;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (cfg_upd_req_i) state_d = DRAIN;
      DRAIN:   if (!cfg_upd_req_i) state_d = RUN;
               else if (!s1_valid_q && !s2_valid_q) state_d = HOLD;
      HOLD:    if (!cfg_upd_req_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      rr_ptr_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_req_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_allow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_req_q   <= s1_req_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_allow_q <= s2_allow_d;
    end
  end

  pmp #(
    .PLEN       (CHK_PLEN),
    .PMP_LEN    (PMP_LEN),
    .NR_ENTRIES (NR_ENTRIES)
  ) i_pmp (
    .addr_i         (s1_req_q.addr),
    .access_type_i  (s1_req_q.access_type),
    .priv_lvl_i     (s1_req_q.priv_lvl),
    .expected_dom_i (s1_req_q.expected_dom),
    .conf_addr_i    (conf_addr_i),
    .conf_i         (pmpconf_i),
    .dmpconf_i      (dmpconf_i),
    .allow_o        (pmp_allow)
  );

  assign rsp_valid_o   = s2_valid_q ? s2_id_q : '0;
  assign rsp_allow_o   = s2_allow_q;
  assign cfg_upd_ack_o = (state_q == HOLD);

endmodule
